pt_hit_conditioner: RTL
=======================

Name: pt_hit_conditioner

Overview:
- Sits directly upstream of the memory-mapped game RAM.
- Takes the four raw photo-transistor target inputs (top-left, top-right, bottom-left, bottom-right) from the board pins and synchronizes, debounces and gates each one by its target LED.
- Drives a stretched hit level into the RAM's PT inputs, which the CPU polls.
- A hit is counted only while the target is lit. Each hit is held long enough for software polling, then re-armed only after the light drops.

Parameters:
- NUM_CH, 4, number of target channels (bit order: 0=top_left, 1=top_right, 2=bottom_left, 3=bottom_right).
- DEBOUNCE_CYCLES, 50000, cycles the synchronized input must stay active before a hit is declared (1 ms at 50 MHz).
- STRETCH_CYCLES, 2500000, maximum cycles pt_hit is held high (50 ms).
- PT_ACTIVE_LOW, 1, 1 = raw input active when 0; 0 = active when 1.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, synchronous active-low reset.
- pt_raw, input, NUM_CH, asynchronous photo-transistor pins.
- led_on, input, NUM_CH, target-lit flags from the RAM LED outputs.
- clear_hit, input, NUM_CH, per-channel early release of a held hit.
- pt_hit, output, NUM_CH, held hit level to the RAM PT inputs.
- hit_pulse, output, NUM_CH, one-cycle strobe on hit declaration.
- hit_count, output, 8, total hits (see Optional Feature).

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-low on reset_n, sampled on the rising edge of clk.
  - While reset_n=0, at the next edge: all synchronizer flops, counters and FSMs clear; every channel goes to IDLE; pt_hit=0, hit_pulse=0, hit_count=0.
  - Reset mid-debounce or mid-hold aborts that channel with no pulse.
- Synchronizer:
  - 2-flop synchronizer per channel, then polarity normalise: act[i] = sync[i] XOR PT_ACTIVE_LOW.
  - Counters are sized $clog2 of their limit.
- Per-channel FSM, independent per channel:
  - IDLE: pt_hit=0. act=1 and led_on=1 -> DEBOUNCE, dcnt=0.
  - DEBOUNCE: act=0 or led_on=0 -> IDLE (dcnt cleared). Otherwise dcnt++. When dcnt==DEBOUNCE_CYCLES-1 with act=1 and led_on=1 -> HOLD, scnt=0, hit_pulse=1 for exactly that transition cycle.
  - HOLD: pt_hit=1, scnt++. scnt==STRETCH_CYCLES-1 or clear_hit[i]=1 -> RELEASE. led_on or act changes are ignored.
  - RELEASE: pt_hit=0. Stay until act=0 is sampled, then -> IDLE. This prevents retrigger from a constantly lit sensor.
- Outputs:
  - pt_hit and hit_pulse are registered, decoded from the state register.
  - Latency: with pt_raw active and led_on=1 held from edge 0, pt_hit and hit_pulse first read 1 after edge DEBOUNCE_CYCLES+3.
  - pt_hit then stays high for exactly STRETCH_CYCLES cycles unless cleared.
- Boundary conditions:
  - clear_hit and stretch expiry in the same cycle: single transition to RELEASE.
  - clear_hit in any state other than HOLD: ignored.
  - led_on dropping on the final debounce cycle: no hit.
  - All four channels hitting in the same cycle: all four pulse together.
  - DEBOUNCE_CYCLES=1 must work: hit on the cycle after entering DEBOUNCE.

Optional Feature:
- Macro: PT_HIT_COUNTER_EN.
- Defined: hit_count increments by popcount(hit_pulse) each cycle and saturates at 255 (never wraps). It is cleared only by reset.
- Undefined: no counter logic; hit_count is tied to 8'd0.

Test Plan:
- DEBOUNCE_CYCLES=4, STRETCH_CYCLES=10, PT_ACTIVE_LOW=1, led_on=4'b0001, pt_raw[0] driven 0 and held -> pt_hit[0]=1 after edge 7, hit_pulse[0] high exactly 1 cycle, pt_hit[0] high exactly 10 cycles, then 0 while pt_raw[0] stays 0; no second hit until pt_raw[0]=1 for 3+ cycles.
- Glitch: pt_raw[1] low for 3 cycles, led_on[1]=1 -> pt_hit[1] stays 0, hit_pulse never asserts.
- Gating: led_on=0, pt_raw all active for 50 cycles -> pt_hit=0. Same run with led_on[2] dropping on the last debounce cycle -> no hit.
- Early clear: during HOLD on channel 3, clear_hit[3]=1 for one cycle at scnt=2 -> pt_hit[3] falls the next edge. clear_hit[3] asserted in IDLE -> no effect.
- Reset mid-hold: reset_n=0 for 1 edge during HOLD -> pt_hit=0 and hit_count=0 after that edge; channel back in IDLE, re-hit needs full debounce.
- With PT_HIT_COUNTER_EN defined: four simultaneous hits -> hit_count +4 in one cycle; 70 rounds of 4 -> hit_count saturates at 255. Without the macro -> hit_count=0 throughout.

Source files
------------

// File: rtl/pt_hit_conditioner.sv
// Photo-transistor hit conditioner: sync, debounce, LED-gate and stretch each target input for CPU polling.
// Latency: hit declared DEBOUNCE_CYCLES+3 edges after input activity; no backpressure, hits are level-held.
// Optional saturating hit counter enabled by defining PT_HIT_COUNTER_EN (otherwise hit_count reads 0).
module pt_hit_conditioner #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int STRETCH_CYCLES  = 2500000,
    parameter bit PT_ACTIVE_LOW   = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] pt_raw,
    input  logic [NUM_CH-1:0] led_on,
    input  logic [NUM_CH-1:0] clear_hit,
    output logic [NUM_CH-1:0] pt_hit,
    output logic [NUM_CH-1:0] hit_pulse,
    output logic [7:0]        hit_count
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] S_LAST = SW'(STRETCH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RELEASE} state_t;

    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] act;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pt_raw;
            sync2 <= sync1;
        end
    end

    assign act = sync2 ^ {NUM_CH{PT_ACTIVE_LOW}};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t        state;
        logic [DW-1:0] dcnt;
        logic [SW-1:0] scnt;
        logic          hit_q;
        logic          pulse_q;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state   <= IDLE;
                dcnt    <= '0;
                scnt    <= '0;
                hit_q   <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                case (state)
                    IDLE: begin
                        if (act[i] && led_on[i]) begin
                            state <= DEBOUNCE;
                            dcnt  <= '0;
                        end
                    end
                    DEBOUNCE: begin
                        if (!act[i] || !led_on[i]) begin
                            state <= IDLE;
                            dcnt  <= '0;
                        end else if (dcnt == D_LAST) begin
                            state   <= HOLD;
                            dcnt    <= '0;
                            scnt    <= '0;
                            hit_q   <= 1'b1;
                            pulse_q <= 1'b1;
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                    HOLD: begin
                        // Light/sensor changes are ignored so software always sees the full hold.
                        if (clear_hit[i] || (scnt == S_LAST)) begin
                            state <= RELEASE;
                            scnt  <= '0;
                            hit_q <= 1'b0;
                        end else begin
                            scnt <= scnt + SW'(1);
                        end
                    end
                    RELEASE: begin
                        if (!act[i]) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        hit_q <= 1'b0;
                    end
                endcase
            end
        end

        assign pt_hit[i]    = hit_q;
        assign hit_pulse[i] = pulse_q;
    end

`ifdef PT_HIT_COUNTER_EN
    logic [7:0]  hit_count_q;
    logic [15:0] cnt_sum;

    always_comb begin
        cnt_sum = 16'(hit_count_q);
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_sum = cnt_sum + 16'(hit_pulse[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_count_q <= 8'd0;
        end else begin
            hit_count_q <= (cnt_sum > 16'd255) ? 8'd255 : cnt_sum[7:0];
        end
    end

    assign hit_count = hit_count_q;
`else
    assign hit_count = 8'd0;
`endif

endmodule
